ex_operand_stage: RTL and testbench

ID/EX pipeline register combined with EX-stage operand forwarding and selection.
- Captures decoded operands and control each cycle, then resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives SrcA, SrcB and Operation directly into the ALU.
- Flags load-use hazards to the hazard controller.

---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/fwd_unit.sv | 24 ++
 rtl/ex_operand_stage.sv | 211 +++++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the EX operand stage: ALU codes, operand-select encodings
// and control-bundle bit positions.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SRA = 4'b0101,
    ALU_SLL = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_BEQ = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_BGE = 4'b1010,
    ALU_BLT = 4'b1011,
    ALU_BNE = 4'b1100,
    ALU_LUI = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_A_REG  = 2'b00,
    SRC_A_PC   = 2'b01,
    SRC_A_ZERO = 2'b10,
    SRC_A_RSVD = 2'b11
  } src_a_sel_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_EXM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // Control bundle layout: {reg_write, mem_read, mem_write}
  localparam int unsigned CTRL_W         = 3;
  localparam int unsigned CTRL_REG_WRITE = 2;
  localparam int unsigned CTRL_MEM_READ  = 1;
  localparam int unsigned CTRL_MEM_WRITE = 0;

endpackage

// File: rtl/fwd_unit.sv
// Per-operand forwarding select: EX/MEM has priority over MEM/WB, x0 never forwarded.
module fwd_unit
  import riscv_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic                  exm_reg_write_i,
  input  logic [REG_ADDR_W-1:0] exm_rd_i,
  input  logic                  wb_reg_write_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  output fwd_sel_e              sel_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (exm_reg_write_i && (exm_rd_i != '0) && (exm_rd_i == rs_i)) begin
      sel_o = FWD_EXM;
    end else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == rs_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with EX-stage operand forwarding, ALU source muxing and
// load-use detection. Optional counters under `EX_OPERAND_PERF_EN.
module ex_operand_stage
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4,
  parameter int unsigned REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     id_valid_i,
  input  logic [DATA_WIDTH-1:0]    id_pc_i,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data_i,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data_i,
  input  logic [DATA_WIDTH-1:0]    id_imm_i,
  input  logic [REG_ADDR_W-1:0]    id_rs1_i,
  input  logic [REG_ADDR_W-1:0]    id_rs2_i,
  input  logic [REG_ADDR_W-1:0]    id_rd_i,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op_i,
  input  logic [1:0]               id_src_a_sel_i,
  input  logic                     id_src_b_imm_i,
  input  logic [2:0]               id_ctrl_i,
  input  logic                     exm_reg_write_i,
  input  logic [REG_ADDR_W-1:0]    exm_rd_i,
  input  logic [DATA_WIDTH-1:0]    exm_result_i,
  input  logic                     wb_reg_write_i,
  input  logic [REG_ADDR_W-1:0]    wb_rd_i,
  input  logic [DATA_WIDTH-1:0]    wb_data_i,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     ex_valid_o,
  output logic [REG_ADDR_W-1:0]    ex_rd_o,
  output logic [2:0]               ex_ctrl_o,
  output logic [DATA_WIDTH-1:0]    ex_store_data_o,
  output logic                     load_use_hazard_o
`ifdef EX_OPERAND_PERF_EN
  ,
  output logic [31:0]              bubble_cnt_o,
  output logic [31:0]              fwd_cnt_o
`endif
);

  logic                     valid_q,     valid_d;
  logic [DATA_WIDTH-1:0]    pc_q,        pc_d;
  logic [DATA_WIDTH-1:0]    rs1_data_q,  rs1_data_d;
  logic [DATA_WIDTH-1:0]    rs2_data_q,  rs2_data_d;
  logic [DATA_WIDTH-1:0]    imm_q,       imm_d;
  logic [REG_ADDR_W-1:0]    rs1_q,       rs1_d;
  logic [REG_ADDR_W-1:0]    rs2_q,       rs2_d;
  logic [REG_ADDR_W-1:0]    rd_q,        rd_d;
  logic [OPCODE_LENGTH-1:0] alu_op_q,    alu_op_d;
  logic [1:0]               src_a_sel_q, src_a_sel_d;
  logic                     src_b_imm_q, src_b_imm_d;
  logic [CTRL_W-1:0]        ctrl_q,      ctrl_d;

  fwd_sel_e              fwd_a_sel, fwd_b_sel;
  logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    alu_op_d    = alu_op_q;
    src_a_sel_d = src_a_sel_q;
    src_b_imm_d = src_b_imm_q;
    ctrl_d      = ctrl_q;
    if (flush_i) begin
      valid_d     = 1'b0;
      pc_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      alu_op_d    = '0;
      src_a_sel_d = '0;
      src_b_imm_d = 1'b0;
      ctrl_d      = '0;
    end else if (!stall_i) begin
      valid_d     = id_valid_i;
      pc_d        = id_pc_i;
      rs1_data_d  = id_rs1_data_i;
      rs2_data_d  = id_rs2_data_i;
      imm_d       = id_imm_i;
      rs1_d       = id_rs1_i;
      rs2_d       = id_rs2_i;
      rd_d        = id_rd_i;
      alu_op_d    = id_alu_op_i;
      src_a_sel_d = id_src_a_sel_i;
      src_b_imm_d = id_src_b_imm_i;
      ctrl_d      = id_valid_i ? id_ctrl_i : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_op_q    <= '0;
      src_a_sel_q <= '0;
      src_b_imm_q <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_op_q    <= alu_op_d;
      src_a_sel_q <= src_a_sel_d;
      src_b_imm_q <= src_b_imm_d;
      ctrl_q      <= ctrl_d;
    end
  end

  fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_i            (rs1_q),
    .exm_reg_write_i (exm_reg_write_i),
    .exm_rd_i        (exm_rd_i),
    .wb_reg_write_i  (wb_reg_write_i),
    .wb_rd_i         (wb_rd_i),
    .sel_o           (fwd_a_sel)
  );

  fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_i            (rs2_q),
    .exm_reg_write_i (exm_reg_write_i),
    .exm_rd_i        (exm_rd_i),
    .wb_reg_write_i  (wb_reg_write_i),
    .wb_rd_i         (wb_rd_i),
    .sel_o           (fwd_b_sel)
  );

  always_comb begin
    case (fwd_a_sel)
      FWD_EXM: fwd_rs1 = exm_result_i;
      FWD_WB:  fwd_rs1 = wb_data_i;
      default: fwd_rs1 = rs1_data_q;
    endcase
    case (fwd_b_sel)
      FWD_EXM: fwd_rs2 = exm_result_i;
      FWD_WB:  fwd_rs2 = wb_data_i;
      default: fwd_rs2 = rs2_data_q;
    endcase
  end

  // Reserved select encoding falls through to zero alongside SRC_A_ZERO
  always_comb begin
    case (src_a_sel_e'(src_a_sel_q))
      SRC_A_REG: SrcA = fwd_rs1;
      SRC_A_PC:  SrcA = pc_q;
      default:   SrcA = '0;
    endcase
  end

  assign SrcB            = src_b_imm_q ? imm_q : fwd_rs2;
  assign ex_store_data_o = fwd_rs2;
  assign Operation       = alu_op_q;
  assign ex_valid_o      = valid_q;
  assign ex_rd_o         = rd_q;
  assign ex_ctrl_o       = ctrl_q;

  assign load_use_hazard_o = id_valid_i && valid_q && ctrl_q[CTRL_MEM_READ] &&
                             (rd_q != '0) &&
                             ((rd_q == id_rs1_i) || (rd_q == id_rs2_i));

`ifdef EX_OPERAND_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] fwd_cnt_q,    fwd_cnt_d;
  logic [1:0]  fwd_num;

  always_comb begin
    fwd_num      = {1'b0, fwd_a_sel != FWD_REG} + {1'b0, fwd_b_sel != FWD_REG};
    bubble_cnt_d = flush_i ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
    fwd_cnt_d    = (valid_q && !stall_i) ? fwd_cnt_q + {30'd0, fwd_num} : fwd_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      fwd_cnt_q    <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      fwd_cnt_q    <= fwd_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
  assign fwd_cnt_o    = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed, table-driven bench for ex_operand_stage plus hand sequences for
// load-use, stall/flush priority and asynchronous reset.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, id_valid_i;
  logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [3:0]  id_alu_op_i;
  logic [1:0]  id_src_a_sel_i;
  logic        id_src_b_imm_i;
  logic [2:0]  id_ctrl_i;
  logic        exm_reg_write_i;
  logic [4:0]  exm_rd_i;
  logic [31:0] exm_result_i;
  logic        wb_reg_write_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic [31:0] SrcA, SrcB, ex_store_data_o;
  logic [3:0]  Operation;
  logic        ex_valid_o;
  logic [4:0]  ex_rd_o;
  logic [2:0]  ex_ctrl_o;
  logic        load_use_hazard_o;
`ifdef EX_OPERAND_PERF_EN
  logic [31:0] bubble_cnt_o, fwd_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_W(5)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .id_valid_i        (id_valid_i),
    .id_pc_i           (id_pc_i),
    .id_rs1_data_i     (id_rs1_data_i),
    .id_rs2_data_i     (id_rs2_data_i),
    .id_imm_i          (id_imm_i),
    .id_rs1_i          (id_rs1_i),
    .id_rs2_i          (id_rs2_i),
    .id_rd_i           (id_rd_i),
    .id_alu_op_i       (id_alu_op_i),
    .id_src_a_sel_i    (id_src_a_sel_i),
    .id_src_b_imm_i    (id_src_b_imm_i),
    .id_ctrl_i         (id_ctrl_i),
    .exm_reg_write_i   (exm_reg_write_i),
    .exm_rd_i          (exm_rd_i),
    .exm_result_i      (exm_result_i),
    .wb_reg_write_i    (wb_reg_write_i),
    .wb_rd_i           (wb_rd_i),
    .wb_data_i         (wb_data_i),
    .SrcA              (SrcA),
    .SrcB              (SrcB),
    .Operation         (Operation),
    .ex_valid_o        (ex_valid_o),
    .ex_rd_o           (ex_rd_o),
    .ex_ctrl_o         (ex_ctrl_o),
    .ex_store_data_o   (ex_store_data_o),
    .load_use_hazard_o (load_use_hazard_o)
`ifdef EX_OPERAND_PERF_EN
    ,
    .bubble_cnt_o      (bubble_cnt_o),
    .fwd_cnt_o         (fwd_cnt_o)
`endif
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic [1:0]  asel;
    logic        bimm;
    logic [2:0]  ctrl;
    logic        exm_we;
    logic [4:0]  exm_rd;
    logic [31:0] exm_res;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_dat;
    logic [31:0] e_srca, e_srcb;
    logic [3:0]  e_op;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic [2:0]  e_ctrl;
    logic [31:0] e_store;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid_i      = v.valid;
    id_pc_i         = v.pc;
    id_rs1_data_i   = v.rs1d;
    id_rs2_data_i   = v.rs2d;
    id_imm_i        = v.imm;
    id_rs1_i        = v.rs1;
    id_rs2_i        = v.rs2;
    id_rd_i         = v.rd;
    id_alu_op_i     = v.op;
    id_src_a_sel_i  = v.asel;
    id_src_b_imm_i  = v.bimm;
    id_ctrl_i       = v.ctrl;
    exm_reg_write_i = v.exm_we;
    exm_rd_i        = v.exm_rd;
    exm_result_i    = v.exm_res;
    wb_reg_write_i  = v.wb_we;
    wb_rd_i         = v.wb_rd;
    wb_data_i       = v.wb_dat;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".SrcA"},  SrcA, 32'd0);
    check({tag, ".SrcB"},  SrcB, 32'd0);
    check({tag, ".Op"},    {28'd0, Operation}, 32'd0);
    check({tag, ".valid"}, {31'd0, ex_valid_o}, 32'd0);
    check({tag, ".rd"},    {27'd0, ex_rd_o}, 32'd0);
    check({tag, ".ctrl"},  {29'd0, ex_ctrl_o}, 32'd0);
    check({tag, ".store"}, ex_store_data_o, 32'd0);
  endtask

  initial begin
    //            valid pc        rs1d      rs2d      imm        rs1 rs2 rd  op      asel  bimm ctrl    exm_we rd  res      wb_we rd  dat      e_srca    e_srcb     e_op    ev  erd e_ctrl  e_store
    vecs[0] = '{1'b1, 32'h0,    32'd5,    32'd9,    32'd7,     5'd1, 5'd2, 5'd3, 4'b0010, 2'b00, 1'b1, 3'b100, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  32'd5,    32'd7,     4'b0010, 1'b1, 5'd3, 3'b100, 32'd9};
    vecs[1] = '{1'b1, 32'h0,    32'h11,   32'h22,   32'h0,     5'd3, 5'd4, 5'd8, 4'b0001, 2'b00, 1'b0, 3'b100, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 32'hAA,   32'h22,    4'b0001, 1'b1, 5'd8, 3'b100, 32'h22};
    vecs[2] = '{1'b1, 32'h0,    32'h11,   32'h22,   32'h0,     5'd3, 5'd4, 5'd8, 4'b0001, 2'b00, 1'b0, 3'b100, 1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 32'hBB,   32'h22,    4'b0001, 1'b1, 5'd8, 3'b100, 32'h22};
    vecs[3] = '{1'b1, 32'h0,    32'h0,    32'h50,   32'h0,     5'd0, 5'd5, 5'd9, 4'b0011, 2'b00, 1'b0, 3'b100, 1'b1, 5'd0, 32'hFF, 1'b1, 5'd5, 32'h55, 32'h0,    32'h55,    4'b0011, 1'b1, 5'd9, 3'b100, 32'h55};
    vecs[4] = '{1'b1, 32'h0,    32'h77,   32'h60,   32'h1234,  5'd7, 5'd6, 5'd1, 4'b0010, 2'b00, 1'b1, 3'b001, 1'b1, 5'd6, 32'h66, 1'b0, 5'd7, 32'hCC, 32'h77,   32'h1234,  4'b0010, 1'b1, 5'd1, 3'b001, 32'h66};
    vecs[5] = '{1'b1, 32'h100,  32'h33,   32'h44,   32'h8,     5'd2, 5'd2, 5'd2, 4'b0010, 2'b01, 1'b1, 3'b100, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  32'h100,  32'h8,     4'b0010, 1'b1, 5'd2, 3'b100, 32'h44};
    vecs[6] = '{1'b1, 32'h100,  32'h33,   32'h44,   32'h8,     5'd2, 5'd2, 5'd2, 4'b1101, 2'b10, 1'b1, 3'b100, 1'b1, 5'd2, 32'h9,  1'b0, 5'd0, 32'h0,  32'h0,    32'h8,     4'b1101, 1'b1, 5'd2, 3'b100, 32'h9};
    vecs[7] = '{1'b1, 32'h200,  32'h33,   32'h44,   32'h8,     5'd2, 5'd2, 5'd2, 4'b0110, 2'b11, 1'b0, 3'b100, 1'b0, 5'd0, 32'h0,  1'b1, 5'd2, 32'hD,  32'h0,    32'hD,     4'b0110, 1'b1, 5'd2, 3'b100, 32'hD};
    vecs[8] = '{1'b0, 32'h0,    32'h12,   32'h34,   32'h0,     5'd1, 5'd2, 5'd6, 4'b0100, 2'b00, 1'b0, 3'b111, 1'b0, 5'd0, 32'h0,  1'b0, 5'd1, 32'hEE, 32'h12,   32'h34,    4'b0100, 1'b0, 5'd6, 3'b000, 32'h34};
    vecs[9] = '{1'b1, 32'h0,    32'h12,   32'h34,   32'h0,     5'd1, 5'd2, 5'd6, 4'b1001, 2'b00, 1'b0, 3'b110, 1'b0, 5'd1, 32'h99, 1'b1, 5'd2, 32'hEE, 32'h12,   32'hEE,    4'b1001, 1'b1, 5'd6, 3'b110, 32'hEE};

    rst_n   = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    drive(vecs[0]);
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d.SrcA", i),  SrcA, vecs[i].e_srca);
      check($sformatf("v%0d.SrcB", i),  SrcB, vecs[i].e_srcb);
      check($sformatf("v%0d.Op", i),    {28'd0, Operation}, {28'd0, vecs[i].e_op});
      check($sformatf("v%0d.valid", i), {31'd0, ex_valid_o}, {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d.rd", i),    {27'd0, ex_rd_o}, {27'd0, vecs[i].e_rd});
      check($sformatf("v%0d.ctrl", i),  {29'd0, ex_ctrl_o}, {29'd0, vecs[i].e_ctrl});
      check($sformatf("v%0d.store", i), ex_store_data_o, vecs[i].e_store);
    end

    // Load-use: load rd=4 in EX, dependent instruction in ID
    @(negedge clk);
    drive(vecs[0]);
    id_rd_i   = 5'd4;
    id_ctrl_i = 3'b110;
    @(posedge clk);
    #1;
    id_rs1_i = 5'd1; id_rs2_i = 5'd4; id_valid_i = 1'b1;
    #1;
    check("lu.rs2_hit", {31'd0, load_use_hazard_o}, 32'd1);
    id_rs1_i = 5'd4; id_rs2_i = 5'd7;
    #1;
    check("lu.rs1_hit", {31'd0, load_use_hazard_o}, 32'd1);
    id_valid_i = 1'b0;
    #1;
    check("lu.id_invalid", {31'd0, load_use_hazard_o}, 32'd0);
    id_valid_i = 1'b1; id_rs1_i = 5'd5; id_rs2_i = 5'd6;
    #1;
    check("lu.no_match", {31'd0, load_use_hazard_o}, 32'd0);
    id_rs2_i = 5'd4;
    stall_i = 1'b1; flush_i = 1'b1;
    exm_reg_write_i = 1'b0; wb_reg_write_i = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("lu.flush");
    check("lu.after_flush", {31'd0, load_use_hazard_o}, 32'd0);

    // Non-load in EX with matching rd raises no hazard
    @(negedge clk);
    stall_i = 1'b0; flush_i = 1'b0;
    drive(vecs[0]);
    id_rd_i = 5'd4;
    @(posedge clk);
    #1;
    id_rs2_i = 5'd4;
    #1;
    check("lu.not_load", {31'd0, load_use_hazard_o}, 32'd0);

    // Stall hold over three edges while ID inputs change
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk);
    #1;
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(vecs[k + 5]);
      exm_reg_write_i = 1'b0; wb_reg_write_i = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("stall%0d.SrcA", k),  SrcA, 32'd5);
      check($sformatf("stall%0d.SrcB", k),  SrcB, 32'd7);
      check($sformatf("stall%0d.Op", k),    {28'd0, Operation}, 32'h2);
      check($sformatf("stall%0d.rd", k),    {27'd0, ex_rd_o}, 32'd3);
      check($sformatf("stall%0d.store", k), ex_store_data_o, 32'd9);
      check($sformatf("stall%0d.valid", k), {31'd0, ex_valid_o}, 32'd1);
    end
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("stall_flush");
    stall_i = 1'b0; flush_i = 1'b0;

    // Asynchronous reset between edges
    @(negedge clk);
    drive(vecs[5]);
    @(posedge clk);
    #1;
    check("prerst.SrcA", SrcA, 32'h100);
    exm_reg_write_i = 1'b0; wb_reg_write_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
